uart_rx_key_decoder: RTL and testbench
======================================

# uart_rx_key_decoder

Parametrised UART receiver with multi-key command decoding. It samples an asynchronous serial line, reassembles frames with a configurable data width and parity mode, and flags framing and parity errors. Each cleanly received byte is compared against a table of key codes, and every match drives its own output channel in toggle or pulse mode. It serves as the board-level serial command front end, e.g. for keyboard-driven reset and mode switches.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 9_600, line baud rate
- OVERSAMPLE, 16, sample ticks per bit; even, ≥4
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- NUM_KEYS, 2, number of key channels, ≥1
- KEYS, {8'h62, 8'h61}, packed key table of width NUM_KEYS*DATA_BITS; channel i uses KEYS[i*DATA_BITS +: DATA_BITS]
- KEY_MODE, 0, key action: 0 toggles the channel, 1 gives a one-cycle pulse
- clk  in  1  system clock; everything is on its rising edge
- rst  in  1  asynchronous, active-high reset
- uart_in  in  1  serial line; idles high; LSB first
- rx_data  out  DATA_BITS  last received data word
- rx_valid  out  1  one-cycle pulse at frame completion
- frame_err  out  1  stop bit of the last frame sampled low
- parity_err  out  1  parity mismatch in the last frame (always 0 when PARITY=0)
- key_out  out  NUM_KEYS  per-channel key outputs

## Operation
- Synchroniser: uart_in passes through 2 flops, both reset to 1. All sampling uses the synchronised value rxs.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, must be ≥1.
  - The counter runs 0..DIV-1 continuously. tick is high for the one cycle when the counter equals DIV-1.
- Sample counter: $clog2(OVERSAMPLE) bits. It advances only on ticks and is cleared on every bit sample.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER. All transitions happen only on tick.
  - IDLE: when rxs=0, go to START and clear the sample counter.
  - START: when the sample counter reaches OVERSAMPLE/2-1, sample rxs. If 1, it is a glitch: return to IDLE with no outputs. If 0, go to DATA with the bit count at 0.
  - DATA: when the sample counter reaches OVERSAMPLE-1, shift rxs in at the MSB and shift right (LSB first). After DATA_BITS samples, go to PARITY, or to STOP when PARITY=0.
  - PARITY: sample at OVERSAMPLE-1.
    - Odd mode: error when XOR(data, pbit) = 0.
    - Even mode: error when XOR(data, pbit) = 1.
  - STOP: sample at OVERSAMPLE-1.
    - Load rx_data, frame_err = ~rxs and parity_err, and pulse rx_valid.
    - If rxs=1, go to IDLE. If rxs=0, go to RECOVER.
  - RECOVER: wait for a tick with rxs=1, then go to IDLE. A held-low line (break) cannot start a phantom frame.
- Key match:
  - Applies on rx_valid with frame_err=0 and parity_err=0.
  - Every channel i whose key equals rx_data acts: toggle when KEY_MODE=0, one-cycle high when KEY_MODE=1.
  - Duplicate keys act on all matching channels.
  - Errored frames never change key_out.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, key_out=0, FSM in IDLE, both counters 0, synchroniser flops 1.
- rx_valid is high exactly one clk cycle, the cycle after the stop-sample tick edge. rx_data, frame_err and parity_err update on that same edge and hold until the next frame completes.
- key_out updates on the edge after rx_valid, giving 1 cycle of match latency. In pulse mode, key_out is high for exactly 1 cycle.
- The stop sample falls about 0.5 bit after the stop bit starts, which permits back-to-back frames. A new start edge is detected on the first tick after the return to IDLE.
- Reset mid-frame aborts the frame: no rx_valid, and all outputs return to reset values immediately (asynchronous).
- rx_valid has no backpressure. A consumer that misses the pulse loses the word.

## Test plan
Common bench settings: CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, which gives DIV=10 and 160 clk per bit. Remaining parameters are at their defaults unless a scenario says otherwise.
- Send 0x61 in 8N1 → one rx_valid pulse, rx_data=0x61, key_out 00→01. Send 0x61 again → key_out 01→00.
- Send 0x55, then 0x62 back-to-back with no idle gap → two rx_valid pulses with rx_data 0x55 then 0x62, and key_out[1] toggles only after the second.
- Send 0x61 with the stop bit low, then hold the line low for 3 bit times → frame_err=1, key_out unchanged, no further rx_valid until the line goes high. Then send a clean 0x62 → frame_err=0 and key_out[1] toggles.
- Drive a 30-clk low glitch on an idle line → no rx_valid; the FSM is back in IDLE within 8 ticks.
- With PARITY=2, send 0x61 with parity bit 0 → parity_err=1 and key_out unchanged. Resend with parity bit 1 → parity_err=0 and key_out[0] toggles.
- With KEY_MODE=1, send 0x61 → key_out[0] high for exactly 1 cycle. Assert rst mid-DATA on the next frame → all outputs 0 at once, and a full 0x62 frame sent afterwards is received correctly.

Source files
------------

// File: rtl/uart_rx_key_decoder.sv
// Oversampled UART receiver whose clean bytes are matched against a key table driving per-channel outputs.
// Latency: rx_valid 1 clk after the stop-sample tick; key_out 1 clk after rx_valid.
// Backpressure: none; rx_valid is a single-cycle pulse and a missed word is lost.
module uart_rx_key_decoder #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9_600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int NUM_KEYS   = 2,
    parameter logic [NUM_KEYS*DATA_BITS-1:0] KEYS = {8'h62, 8'h61},
    parameter int KEY_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic [NUM_KEYS-1:0]  key_out
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RECOVER
    } state_t;

    state_t               state, state_nxt;
    logic                 sync_q, rxs;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [SW-1:0]        scnt, scnt_nxt;
    logic [BW-1:0]        bcnt, bcnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 perr_q, perr_nxt;
    logic                 done;
    logic [NUM_KEYS-1:0]  hit;
    logic                 key_act;

    // Both stages reset high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_q <= uart_in;
            rxs    <= sync_q;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            scnt   <= '0;
            bcnt   <= '0;
            shreg  <= '0;
            perr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            scnt   <= scnt_nxt;
            bcnt   <= bcnt_nxt;
            shreg  <= shreg_nxt;
            perr_q <= perr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        perr_nxt  = perr_q;
        done      = 1'b0;
        if (tick) begin
            scnt_nxt = scnt + SW'(1);
            case (state)
                S_IDLE: begin
                    scnt_nxt = '0;
                    if (!rxs) begin
                        state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (scnt == SAMP_MID) begin
                        scnt_nxt  = '0;
                        bcnt_nxt  = '0;
                        perr_nxt  = 1'b0;
                        state_nxt = rxs ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (scnt == SAMP_END) begin
                        scnt_nxt  = '0;
                        shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
                        bcnt_nxt  = bcnt + BW'(1);
                        if (bcnt == BIT_LAST) begin
                            state_nxt = (PARITY == 0) ? S_STOP : S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (scnt == SAMP_END) begin
                        scnt_nxt  = '0;
                        perr_nxt  = (PARITY == 1) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
                        state_nxt = S_STOP;
                    end
                end
                S_STOP: begin
                    if (scnt == SAMP_END) begin
                        scnt_nxt  = '0;
                        done      = 1'b1;
                        state_nxt = rxs ? S_IDLE : S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    // A held-low line must go high before a new start edge counts.
                    scnt_nxt = '0;
                    if (rxs) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    scnt_nxt  = '0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_valid <= done;
            if (done) begin
                rx_data    <= shreg;
                frame_err  <= ~rxs;
                parity_err <= perr_q;
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hit[i] = (KEYS[i*DATA_BITS +: DATA_BITS] == rx_data);
        end
    end

    assign key_act = rx_valid && !frame_err && !parity_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out <= '0;
        end else if (KEY_MODE == 0) begin
            if (key_act) begin
                key_out <= key_out ^ hit;
            end
        end else begin
            key_out <= key_act ? hit : '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_key_decoder.sv
// Scoreboard bench: three receivers (8N1 toggle, 8E1 toggle, 8N1 pulse) driven by serial stimulus
// checked against a frame-level model of received words and key channel behaviour.
`timescale 1ns/1ps
module tb_uart_rx_key_decoder;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic [1:0] k;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       line [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] rxd  [3];
    logic       rxv  [3];
    logic       fe   [3];
    logic       pe   [3];
    logic [1:0] ko   [3];

    // Channel behaviour of each instance and the key table channel order.
    int         pmode [3] = '{0, 2, 0};
    int         kmode [3] = '{0, 0, 1};
    logic [7:0] keytab [2] = '{8'h61, 8'h62};

    exp_t       sbq [$];
    logic [1:0] mkey [3] = '{2'b00, 2'b00, 2'b00};
    logic       kdue [3] = '{1'b0, 1'b0, 1'b0};
    logic       zdue [3] = '{1'b0, 1'b0, 1'b0};
    logic [1:0] kexp [3];
    int         vcount [3] = '{0, 0, 0};
    int         nvec = 0;
    int         nfail = 0;

    always #5 clk = ~clk;

    uart_rx_key_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                          .PARITY(0), .KEY_MODE(0)) u0 (
        .clk(clk), .rst(rst), .uart_in(line[0]), .rx_data(rxd[0]), .rx_valid(rxv[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .key_out(ko[0]));

    uart_rx_key_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                          .PARITY(2), .KEY_MODE(0)) u1 (
        .clk(clk), .rst(rst), .uart_in(line[1]), .rx_data(rxd[1]), .rx_valid(rxv[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .key_out(ko[1]));

    uart_rx_key_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                          .PARITY(0), .KEY_MODE(1)) u2 (
        .clk(clk), .rst(rst), .uart_in(line[2]), .rx_data(rxd[2]), .rx_valid(rxv[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .key_out(ko[2]));

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a clean frame toggles (or pulses) every channel whose key equals the byte.
    task automatic predict(input int ch, input logic [7:0] d, input logic ferr, input logic perr);
        exp_t       e;
        logic [1:0] hitv;
        hitv = 2'b00;
        for (int i = 0; i < 2; i++) hitv[i] = (d == keytab[i]);
        e.ch = 2'(ch);
        e.d  = d;
        e.fe = ferr;
        e.pe = perr;
        if (kmode[ch] == 1) begin
            e.k = (!ferr && !perr) ? hitv : 2'b00;
        end else begin
            if (!ferr && !perr) mkey[ch] = mkey[ch] ^ hitv;
            e.k = mkey[ch];
        end
        sbq.push_back(e);
    endtask

    task automatic send(input int ch, input logic [7:0] d, input bit pbad, input bit stop_val,
                        input int idle_bits);
        logic pbit;
        predict(ch, d, !stop_val, (pmode[ch] != 0) && pbad);
        line[ch] = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line[ch] = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (pmode[ch] != 0) begin
            pbit = (pmode[ch] == 1) ? ~(^d) : (^d);
            line[ch] = pbit ^ pbad;
            repeat (BIT_CLKS) @(negedge clk);
        end
        line[ch] = stop_val;
        repeat (BIT_CLKS) @(negedge clk);
        if (idle_bits > 0) begin
            line[ch] = 1'b1;
            repeat (idle_bits * BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("drain_outstanding", sbq.size(), 0);
    endtask

    task automatic rand_byte(output logic [7:0] d);
        int r;
        r = $urandom_range(0, 3);
        d = (r == 0) ? 8'h61 : (r == 1) ? 8'h62 : 8'($urandom);
    endtask

    // Monitor: pops the scoreboard on each rx_valid, then checks key_out on the following cycle(s).
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                kdue[c] = 1'b0;
                zdue[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (zdue[c]) begin
                    zdue[c] = 1'b0;
                    chk($sformatf("key_pulse_end_ch%0d", c), int'(ko[c]), 0);
                end
                if (kdue[c]) begin
                    kdue[c] = 1'b0;
                    chk($sformatf("key_out_ch%0d", c), int'(ko[c]), int'(kexp[c]));
                    if (kmode[c] == 1 && kexp[c] != 2'b00) zdue[c] = 1'b1;
                end
                if (rxv[c]) begin
                    vcount[c]++;
                    if (sbq.size() == 0) begin
                        chk($sformatf("unexpected_rx_valid_ch%0d", c), 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("valid_channel_ch%0d", c), c, int'(e.ch));
                        chk($sformatf("rx_data_ch%0d", c), int'(rxd[c]), int'(e.d));
                        chk($sformatf("frame_err_ch%0d", c), int'(fe[c]), int'(e.fe));
                        chk($sformatf("parity_err_ch%0d", c), int'(pe[c]), int'(e.pe));
                        kdue[c] = 1'b1;
                        kexp[c] = e.k;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         v0;
        bit         sbad;
        bit         pbad;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("reset_outputs_ch%0d", c), int'({rxd[c], rxv[c], fe[c], pe[c], ko[c]}), 0);
        end
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);

        send(0, 8'h61, 0, 1, 1);
        send(0, 8'h61, 0, 1, 1);
        drain();

        send(0, 8'h55, 0, 1, 0);
        send(0, 8'h62, 0, 1, 1);
        drain();

        // Bad stop bit followed by a 3-bit break: exactly one word, no phantom frames.
        v0 = vcount[0];
        send(0, 8'h61, 0, 0, 0);
        line[0] = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        line[0] = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("break_valid_count", vcount[0] - v0, 1);
        send(0, 8'h62, 0, 1, 1);
        drain();

        v0 = vcount[0];
        line[0] = 1'b0;
        repeat (30) @(negedge clk);
        line[0] = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("glitch_valid_count", vcount[0] - v0, 0);
        send(0, 8'h61, 0, 1, 1);
        drain();

        for (int n = 0; n < 10; n++) begin
            rand_byte(d);
            sbad = ($urandom_range(0, 5) == 0);
            send(0, d, 0, !sbad, sbad ? 1 : int'($urandom_range(0, 2)));
        end
        drain();

        send(1, 8'h61, 1, 1, 1);
        send(1, 8'h61, 0, 1, 1);
        drain();
        for (int n = 0; n < 8; n++) begin
            rand_byte(d);
            pbad = ($urandom_range(0, 2) == 0);
            sbad = ($urandom_range(0, 7) == 0);
            send(1, d, pbad, !sbad, sbad ? 1 : int'($urandom_range(0, 2)));
        end
        drain();

        send(2, 8'h61, 0, 1, 1);
        drain();

        // Abort a frame mid-DATA with reset; outputs must clear without waiting for a clock.
        line[2] = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            line[2] = (i == 1);
            repeat (BIT_CLKS) @(negedge clk);
        end
        #3 rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("midframe_reset_ch%0d", c), int'({rxd[c], rxv[c], fe[c], pe[c], ko[c]}), 0);
        end
        sbq.delete();
        for (int c = 0; c < 3; c++) mkey[c] = 2'b00;
        line[2] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send(2, 8'h62, 0, 1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
